// File: rtl/serial_shift_unit_if.sv
// Handshake bundle for the multi-cycle shift/rotate unit: operand side in,
// result side out, plus a busy status flag.
interface serial_shift_unit_if #(
   parameter int N  = 8,
   parameter int AW = $clog2(N) + 1
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  A;
   logic [AW-1:0] amt;
   logic [2:0]    mode;
   logic          CB_in;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  res;
   logic          CB_out;
   logic          busy;

   // Producer/consumer side that drives operands and accepts results.
   modport master (
      output in_valid, A, amt, mode, CB_in, out_ready,
      input  in_ready, out_valid, res, CB_out, busy
   );

   // The shift unit itself.
   modport slave (
      input  in_valid, A, amt, mode, CB_in, out_ready,
      output in_ready, out_valid, res, CB_out, busy
   );
endinterface

// File: rtl/serial_shift_unit.sv
// Sequential shift/rotate unit: accepts one bundle, steps one bit per clock
// for amt cycles, then holds res/CB_out until the consumer takes them.
module serial_shift_unit #(
   parameter int N  = 8,
   parameter int AW = $clog2(N) + 1
) (
   input logic               clk,
   input logic               rst_n,
   serial_shift_unit_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   typedef enum logic [2:0] {
      SLL0 = 3'b000,
      SLL1 = 3'b001,
      SRL0 = 3'b010,
      SRL1 = 3'b011,
      RCL  = 3'b100,
      SRA  = 3'b101,
      ROL  = 3'b110,
      ROR  = 3'b111
   } mode_e;

   state_e        state;
   mode_e         mode_q;
   logic [N-1:0]  res_q;
   logic          c_q;
   logic [AW-1:0] cnt_q;
   logic          out_valid_q;
   logic          in_ready_q;
   logic          busy_q;

   logic [N-1:0]  step_r;
   logic          step_c;

   // One bit-step of the selected operation on the held result and carry.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs; no latch.
      step_r = res_q;
      step_c = c_q;
      case (mode_q)
         SLL0: begin step_c = res_q[N-1]; step_r = {res_q[N-2:0], 1'b0};     end
         SLL1: begin step_c = res_q[N-1]; step_r = {res_q[N-2:0], 1'b1};     end
         SRL0: begin step_c = res_q[0];   step_r = {1'b0, res_q[N-1:1]};     end
         SRL1: begin step_c = res_q[0];   step_r = {1'b1, res_q[N-1:1]};     end
         RCL:  begin step_c = res_q[N-1]; step_r = {res_q[N-2:0], c_q};      end
         SRA:  begin step_c = res_q[0];   step_r = {res_q[N-1], res_q[N-1:1]}; end
         ROL:  begin step_c = res_q[N-1]; step_r = {res_q[N-2:0], res_q[N-1]}; end
         ROR:  begin step_c = res_q[0];   step_r = {res_q[0], res_q[N-1:1]}; end
         default: begin step_r = res_q; step_c = c_q; end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      if (!rst_n) begin
         state       <= IDLE;
         mode_q      <= SLL0;
         res_q       <= '0;
         c_q         <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  res_q      <= bus.A;
                  c_q        <= bus.CB_in;
                  mode_q     <= mode_e'(bus.mode);
                  cnt_q      <= bus.amt;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (bus.amt == '0) begin
                     state       <= DONE;
                     out_valid_q <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               res_q <= step_r;
               c_q   <= step_c;
               cnt_q <= cnt_q - AW'(1);
               if (cnt_q == AW'(1)) begin
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.res       = res_q;
   assign bus.CB_out    = c_q;
   assign bus.out_valid = out_valid_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;

endmodule
